// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the reference clock: pulses the PLL reset, waits for a stable lock,
// then releases the core reset. It retries on lock timeout and re-sequences after a lock loss.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lost_count
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_retry, w_retry_nxt;
  logic [7:0]    r_lost, w_lost_nxt;
  logic          r_sync1, r_sync2;
  logic          w_locked_s;

  assign w_locked_s = r_sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= S_RESET_PLL;
      r_cnt   <= '0;
      r_retry <= '0;
      r_lost  <= '0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_lost_nxt  = r_lost;
    if (restart) begin
      w_state_nxt = S_RESET_PLL;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // A lock seen on the last timeout cycle still wins over the retry.
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_cnt_nxt = '0;
            if (r_retry == RETRY_MAX) begin
              w_state_nxt = S_FAIL;
            end else begin
              w_state_nxt = S_RESET_PLL;
              w_retry_nxt = r_retry + 4'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = '0;
            if (r_lost != 8'hFF) w_lost_nxt = r_lost + 8'd1;
          end
        end
        S_FAIL: begin
          w_state_nxt = S_FAIL;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign pll_rst     = (r_state == S_RESET_PLL);
  assign core_reset  = (r_state != S_RUN);
  assign ready       = (r_state == S_RUN);
  assign fail        = (r_state == S_FAIL);
  assign retry_count = r_retry;
  assign lost_count  = r_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-plus-random bench for pll_lock_sequencer; expected latencies and counts come from
// the sequencing rules (pulse length, timeout window, 2-flop sync, stability window).
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TO    = 20;
  localparam int ST    = 8;
  localparam int MR    = 2;

  // Edge k samples locked high, locked_s valid after k+1, STABLE at k+2, RUN at k+2+ST.
  localparam int LAT_READY = 1 + 2 + ST;
  localparam int LAT_LOSS  = 3;

  localparam int SEL_PLL  = 0;
  localparam int SEL_CORE = 1;
  localparam int SEL_RDY  = 2;
  localparam int SEL_FAIL = 3;

  logic       refclk  = 1'b0;
  logic       rst     = 1'b1;
  logic       locked  = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, core_reset, ready, fail;
  logic [3:0] retry_count;
  logic [7:0] lost_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_lost;
  int n;
  int d;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(ST),
    .MAX_RETRY    (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .fail       (fail),
    .retry_count(retry_count),
    .lost_count (lost_count)
  );

  always #5 refclk = ~refclk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_PLL:  return pll_rst;
      SEL_CORE: return core_reset;
      SEL_RDY:  return ready;
      default:  return fail;
    endcase
  endfunction

  // Counts edges until the selected output reaches val; an expired budget returns budget.
  task automatic wait_until(input int sel, input logic val, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sig(sel) !== val && cnt < budget);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) tick();
    check({tag, "_outs"}, {28'd0, pll_rst, core_reset, ready, fail}, 32'b1100);
    check({tag, "_retry"}, {28'd0, retry_count}, 32'd0);
    check({tag, "_lost"}, {24'd0, lost_count}, 32'd0);
    rst = 1'b0;
    exp_lost = 0;
  endtask

  initial begin
    // Scenario 1: nominal bring-up with a random lock delay.
    do_reset("s1_rst");
    wait_until(SEL_PLL, 1'b0, 50, n);
    check("s1_pll_pulse", n, RST_C);
    d = $urandom_range(0, 15);
    repeat (d) tick();
    check("s1_waiting", {28'd0, pll_rst, core_reset, ready, fail}, 32'b0100);
    locked = 1'b1;
    wait_until(SEL_RDY, 1'b1, 100, n);
    check("s1_ready_lat", n, LAT_READY);
    check("s1_core_rel", {31'd0, core_reset}, 32'd0);
    check("s1_retry", {28'd0, retry_count}, 32'd0);

    // Scenario 2: 2-cycle lock drop at stable-count 5 sends it back to WAIT_LOCK.
    locked = 1'b0;
    do_reset("s2_rst");
    wait_until(SEL_PLL, 1'b0, 50, n);
    check("s2_pll_pulse", n, RST_C);
    locked = 1'b1;
    repeat (3 + 5) tick();
    check("s2_in_stable", {28'd0, pll_rst, core_reset, ready, fail}, 32'b0100);
    locked = 1'b0;
    repeat (2) tick();
    locked = 1'b1;
    wait_until(SEL_RDY, 1'b1, 100, n);
    check("s2_ready_lat", n, LAT_READY);
    check("s2_retry", {28'd0, retry_count}, 32'd0);

    // Scenario 3: lock never comes; MR retries then FAIL.
    locked = 1'b0;
    do_reset("s3_rst");
    for (int w = 0; w <= MR; w++) begin
      wait_until(SEL_PLL, 1'b0, 50, n);
      check("s3_pll_pulse", n, RST_C);
      if (w < MR) begin
        wait_until(SEL_PLL, 1'b1, 100, n);
        check("s3_window", n, TO);
        check("s3_retry", {28'd0, retry_count}, w + 1);
      end else begin
        wait_until(SEL_FAIL, 1'b1, 100, n);
        check("s3_fail_window", n, TO);
      end
    end
    check("s3_fail_retry", {28'd0, retry_count}, MR);
    for (int i = 0; i < 120; i++) begin
      locked = 1'($urandom);
      tick();
      check("s3_fail_hold", {28'd0, pll_rst, core_reset, ready, fail}, 32'b0101);
    end

    // Scenario 4: restart out of FAIL; lock arrives on the last cycle before timeout.
    locked = 1'b0;
    repeat (3) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("s4_after_restart", {28'd0, pll_rst, core_reset, ready, fail}, 32'b1100);
    check("s4_retry_clr", {28'd0, retry_count}, 32'd0);
    wait_until(SEL_PLL, 1'b0, 50, n);
    check("s4_pll_pulse", n, RST_C);
    repeat (TO - 3) tick();
    locked = 1'b1;
    wait_until(SEL_RDY, 1'b1, 100, n);
    check("s4_ready_lat", n, LAT_READY);
    check("s4_retry", {28'd0, retry_count}, 32'd0);
    check("s4_fail_clr", {31'd0, fail}, 32'd0);

    // Scenario 5: lock loss in RUN.
    locked = 1'b0;
    wait_until(SEL_CORE, 1'b1, 20, n);
    check("s5_loss_lat", n, LAT_LOSS);
    exp_lost = exp_lost + 1;
    check("s5_lost", {24'd0, lost_count}, exp_lost);
    check("s5_pll_on", {31'd0, pll_rst}, 32'd1);
    wait_until(SEL_PLL, 1'b0, 50, n);
    check("s5_pll_pulse", n, RST_C);
    locked = 1'b1;
    wait_until(SEL_RDY, 1'b1, 100, n);
    check("s5_relock_lat", n, LAT_READY);

    // Restart landing on the same edge as a lock-loss transition keeps lost_count.
    locked = 1'b0;
    repeat (2) tick();
    check("s6_still_run", {31'd0, ready}, 32'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("s6_restart_loss_lost", {24'd0, lost_count}, exp_lost);
    check("s6_restart_loss_outs", {28'd0, pll_rst, core_reset, ready, fail}, 32'b1100);
    locked = 1'b1;
    wait_until(SEL_RDY, 1'b1, 100, n);
    check("s6_relock", {31'd0, ready}, 32'd1);

    // Repeated losses until lost_count saturates.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      wait_until(SEL_CORE, 1'b1, 20, n);
      exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
      check("s5_lost_sat", {24'd0, lost_count}, exp_lost);
      repeat ($urandom_range(0, 6)) tick();
      locked = 1'b1;
      wait_until(SEL_RDY, 1'b1, 100, n);
      check("s5_loop_ready", {31'd0, ready}, 32'd1);
    end
    check("s5_lost_final", {24'd0, lost_count}, 32'd255);

    // Scenario 6: rst and restart together, then rst while in STABLE.
    rst     = 1'b1;
    restart = 1'b1;
    tick();
    rst     = 1'b0;
    restart = 1'b0;
    exp_lost = 0;
    check("s6_both_outs", {28'd0, pll_rst, core_reset, ready, fail}, 32'b1100);
    check("s6_both_lost", {24'd0, lost_count}, exp_lost);
    check("s6_both_retry", {28'd0, retry_count}, 32'd0);
    wait_until(SEL_PLL, 1'b0, 50, n);
    check("s6_pll_pulse", n, RST_C);
    repeat (3) tick();
    check("s6_in_stable", {28'd0, pll_rst, core_reset, ready, fail}, 32'b0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_stable_rst_outs", {28'd0, pll_rst, core_reset, ready, fail}, 32'b1100);
    check("s6_stable_rst_lost", {24'd0, lost_count}, 32'd0);
    check("s6_stable_rst_retry", {28'd0, retry_count}, 32'd0);
    wait_until(SEL_PLL, 1'b0, 50, n);
    check("s6_final_pulse", n, RST_C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
